ddc_bus_arbiter: RTL and testbench
==================================

DDC_BUS_ARBITER -- requirements
Module: ddc_bus_arbiter

Interface
REQ-001 Parameter FREE_CYC, default 16: clk cycles the bus must stay idle after STOP before any grant (tBUF).
REQ-002 Parameter GRANT_TO, default 1024: clk cycles a grantee has to issue START before its grant is revoked.
REQ-003 Parameter STUCK_TO, default 50000: clk cycles of continuous SCL low that count as a stuck bus.
REQ-004 Port clk, input, 1: single clock; every register samples on its rising edge.
REQ-005 Port rst, input, 1: reset, synchronous, active-high.
REQ-006 Port scl_in, input, 1: filtered, clk-synchronous sink-side SCL level.
REQ-007 Port sda_in, input, 1: filtered, clk-synchronous sink-side SDA level.
REQ-008 Port req, input, 2: bus requests; bit0 = host passthrough bridge, bit1 = local EDID master.
REQ-009 Port grant, output, 2: one-hot or zero bus ownership.
REQ-010 Port bus_busy, output, 1: high from a detected START until a detected STOP.
REQ-011 Port hold_host, output, 1: asks the bridge to stretch source SCL; equals req[0] & ~grant[0], registered.
REQ-012 Port bus_err, output, 1: one-cycle pulse on a stuck-bus abort or a grant timeout.

Function
REQ-013 Registered copies of scl_in/sda_in SHALL be kept; START = SDA 1->0 while SCL is 1 in both samples; STOP = SDA 0->1 while SCL is 1 in both samples; either is flagged one cycle after the edge is sampled.
REQ-014 States: IDLE, WAIT_FREE, GRANTED, OWNED, EXT_BUSY.
REQ-015 IDLE: any req bit set -> GRANTED; grant is asserted on the same clock edge as the state change.
REQ-016 Both req bits set in IDLE: the round-robin pointer picks the winner; the pointer then points at the other requester. The pointer resets to requester 0.
REQ-017 GRANTED: START -> OWNED and bus_busy=1.
REQ-018 GRANTED: grantee drops req before START -> grant=00, back to IDLE next cycle.
REQ-019 GRANTED: GRANT_TO cycles with no START -> grant=00, bus_err pulse, IDLE.
REQ-020 OWNED: grant is held until STOP, regardless of req. A repeated START keeps ownership.
REQ-021 OWNED: STOP -> grant=00, bus_busy=0, WAIT_FREE.
REQ-022 WAIT_FREE: count FREE_CYC cycles, then IDLE. A START during WAIT_FREE -> EXT_BUSY.
REQ-023 IDLE: START with no grant (foreign master) -> EXT_BUSY with bus_busy=1; no grants until STOP, then WAIT_FREE.
REQ-024 Every counter SHALL be 16 bits wide, clear on each state entry, and saturate rather than wrap.
REQ-025 grant SHALL never have both bits set, and grant SHALL never change while bus_busy=1, except on a stuck-bus abort.

Reset
REQ-026 While rst=1 at a clk edge: state=IDLE, grant=00, bus_busy=0, hold_host=0, bus_err=0, pointer=0, counters=0, edge samples=1.
REQ-027 Reset asserted mid-transaction SHALL drop grant on that edge; after release, the arbiter SHALL wait for a STOP or FREE_CYC idle cycles before any grant (enter WAIT_FREE).

Configuration
REQ-028 Macro DDC_ARB_STUCK_WDT_EN defined: in OWNED or EXT_BUSY, SCL low for STUCK_TO consecutive cycles -> grant=00, bus_busy=0, bus_err pulse, WAIT_FREE.
REQ-029 Macro DDC_ARB_STUCK_WDT_EN not defined: no stuck counter is built; bus_err comes only from grant timeout; a stuck bus holds the state indefinitely.

Verification
REQ-030 req=01 in IDLE -> grant=01 next edge; START, 9 SCL pulses, STOP -> bus_busy 1 then 0; grant=00 after STOP; no grant for 16 cycles.
REQ-031 req=11 on the same cycle from reset -> grant=01; after that STOP and 16 free cycles, with req=10 held -> grant=10.
REQ-032 req=10 granted, no START for 1024 cycles -> bus_err one-cycle pulse, grant=00, state IDLE.
REQ-033 Foreign START in IDLE with req=01 -> grant stays 00, hold_host=1 until STOP plus 16 cycles, then grant=01.
REQ-034 With the macro defined, OWNED and SCL held low for 50000 cycles -> bus_err pulse, grant=00, bus_busy=0; without the macro -> grant held.
REQ-035 rst=1 in OWNED -> next edge grant=00, bus_busy=0; after release, 16 idle cycles pass before the next grant.

Source files
------------

// File: rtl/ddc_bus_arbiter.sv
// ddc_bus_arbiter: shares the sink-side DDC bus between the host passthrough bridge and the local EDID master.
// Build option: define DDC_ARB_STUCK_WDT_EN to add the stuck-SCL watchdog abort.
module ddc_bus_arbiter #(
  parameter int FREE_CYC = 16,
  parameter int GRANT_TO = 1024,
  parameter int STUCK_TO = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  input  logic [1:0] req,
  output logic [1:0] grant,
  output logic       bus_busy,
  output logic       hold_host,
  output logic       bus_err
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WAIT_FREE = 3'd1;
  localparam logic [2:0] S_GRANTED   = 3'd2;
  localparam logic [2:0] S_OWNED     = 3'd3;
  localparam logic [2:0] S_EXT_BUSY  = 3'd4;

  localparam logic [15:0] FREE_LAST  = 16'(FREE_CYC - 1);
  localparam logic [15:0] GRANT_LAST = 16'(GRANT_TO - 1);

  logic [2:0]  state, state_nxt;
  logic [15:0] cnt;
  logic [1:0]  grant_nxt;
  logic        busy_nxt, err_nxt;
  logic        ptr, ptr_nxt, win;
  logic        post_rst, post_rst_nxt;
  logic        scl_p0, sda_p0;
  logic        start_p1, stop_p1;
  logic        stuck_hit;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Stage 0: line samples; stage 1: START/STOP flags from the sample pair.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_p0   <= 1'b1;
      sda_p0   <= 1'b1;
      start_p1 <= 1'b0;
      stop_p1  <= 1'b0;
    end else begin
      scl_p0   <= scl_in;
      sda_p0   <= sda_in;
      start_p1 <= scl_p0 & scl_in & sda_p0 & ~sda_in;
      stop_p1  <= scl_p0 & scl_in & ~sda_p0 & sda_in;
    end
  end

`ifdef DDC_ARB_STUCK_WDT_EN
  localparam logic [15:0] STUCK_LAST = 16'(STUCK_TO - 1);
  logic [15:0] stk;

  always_ff @(posedge clk) begin
    if (rst || (state_nxt != state) || scl_in) stk <= '0;
    else                                       stk <= sat_inc(stk);
  end

  assign stuck_hit = ~scl_in & (stk == STUCK_LAST);
`else
  // No watchdog in this build; STUCK_TO stays so both builds share one interface.
  assign stuck_hit = (STUCK_TO < 0);
`endif

  always_comb begin
    state_nxt    = state;
    grant_nxt    = grant;
    busy_nxt     = bus_busy;
    err_nxt      = 1'b0;
    ptr_nxt      = ptr;
    post_rst_nxt = post_rst;
    win          = (req == 2'b11) ? ptr : req[1];
    case (state)
      S_IDLE: begin
        if (start_p1) begin
          state_nxt    = S_EXT_BUSY;
          busy_nxt     = 1'b1;
          post_rst_nxt = 1'b0;
        end else if (post_rst) begin
          // Coming out of reset the bus state is unknown, so let it settle first.
          state_nxt    = S_WAIT_FREE;
          post_rst_nxt = 1'b0;
        end else if (req != 2'b00) begin
          state_nxt = S_GRANTED;
          grant_nxt = win ? 2'b10 : 2'b01;
          ptr_nxt   = ~win;
        end
      end
      S_WAIT_FREE: begin
        if (start_p1) begin
          state_nxt = S_EXT_BUSY;
          busy_nxt  = 1'b1;
        end else if (cnt == FREE_LAST) begin
          state_nxt = S_IDLE;
        end
      end
      S_GRANTED: begin
        if (start_p1) begin
          state_nxt = S_OWNED;
          busy_nxt  = 1'b1;
        end else if ((grant & req) == 2'b00) begin
          state_nxt = S_IDLE;
          grant_nxt = 2'b00;
        end else if (cnt == GRANT_LAST) begin
          state_nxt = S_IDLE;
          grant_nxt = 2'b00;
          err_nxt   = 1'b1;
        end
      end
      S_OWNED, S_EXT_BUSY: begin
        if (stop_p1) begin
          state_nxt = S_WAIT_FREE;
          grant_nxt = 2'b00;
          busy_nxt  = 1'b0;
        end else if (stuck_hit) begin
          state_nxt = S_WAIT_FREE;
          grant_nxt = 2'b00;
          busy_nxt  = 1'b0;
          err_nxt   = 1'b1;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        grant_nxt = 2'b00;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      grant     <= 2'b00;
      bus_busy  <= 1'b0;
      hold_host <= 1'b0;
      bus_err   <= 1'b0;
      ptr       <= 1'b0;
      post_rst  <= 1'b1;
      cnt       <= '0;
    end else begin
      state     <= state_nxt;
      grant     <= grant_nxt;
      bus_busy  <= busy_nxt;
      hold_host <= req[0] & ~grant_nxt[0];
      bus_err   <= err_nxt;
      ptr       <= ptr_nxt;
      post_rst  <= post_rst_nxt;
      cnt       <= (state_nxt != state) ? '0 : sat_inc(cnt);
    end
  end

endmodule

// File: tb/tb_ddc_bus_arbiter.sv
// Bench for ddc_bus_arbiter: directed scenarios plus random DDC traffic against a deadline-based reference model.
module tb_ddc_bus_arbiter;

  localparam int FREE_CYC = 16;
  localparam int GRANT_TO = 1024;
  localparam int STUCK_TO = 300;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl_in = 1'b1;
  logic       sda_in = 1'b1;
  logic [1:0] req = 2'b00;
  logic [1:0] grant;
  logic       bus_busy, hold_host, bus_err;

  always #5 clk = ~clk;

  ddc_bus_arbiter #(.FREE_CYC(FREE_CYC), .GRANT_TO(GRANT_TO), .STUCK_TO(STUCK_TO)) dut (
    .clk(clk), .rst(rst), .scl_in(scl_in), .sda_in(sda_in), .req(req),
    .grant(grant), .bus_busy(bus_busy), .hold_host(hold_host), .bus_err(bus_err)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: modes with entry times; timeouts are deadlines measured from entry.
  typedef enum int {M_IDLE, M_WAIT, M_GRANTED, M_OWNED, M_EXT} mode_t;
  mode_t      m_mode = M_IDLE;
  int         m_enter = 0, m_who = 0, m_ptr = 0, m_last_high = 0;
  bit         m_after_rst = 1'b1;
  logic [1:0] m_grant = 2'b00;
  bit         m_busy = 1'b0, m_hold = 1'b0, m_err = 1'b0;
  bit         h_scl1 = 1'b1, h_sda1 = 1'b1, h_scl2 = 1'b1, h_sda2 = 1'b1, h_rst1 = 1'b1;

  task automatic enter(input mode_t md);
    m_mode  = md;
    m_enter = cyc;
  endtask

  task automatic model_step();
    bit start, stop, stuck;
    start = !h_rst1 && h_scl2 && h_scl1 && h_sda2 && !h_sda1;
    stop  = !h_rst1 && h_scl2 && h_scl1 && !h_sda2 && h_sda1;
    stuck = 1'b0;
`ifdef DDC_ARB_STUCK_WDT_EN
    stuck = !scl_in && (cyc - ((m_last_high > m_enter) ? m_last_high : m_enter) == STUCK_TO);
`endif
    if (rst) begin
      enter(M_IDLE);
      m_grant = 2'b00; m_busy = 1'b0; m_err = 1'b0; m_ptr = 0; m_after_rst = 1'b1;
    end else begin
      m_err = 1'b0;
      case (m_mode)
        M_IDLE:
          if (start) begin enter(M_EXT); m_busy = 1'b1; m_after_rst = 1'b0; end
          else if (m_after_rst) begin enter(M_WAIT); m_after_rst = 1'b0; end
          else if (req != 2'b00) begin
            m_who   = (req == 2'b11) ? m_ptr : ((req == 2'b10) ? 1 : 0);
            m_ptr   = 1 - m_who;
            m_grant = (m_who == 1) ? 2'b10 : 2'b01;
            enter(M_GRANTED);
          end
        M_WAIT:
          if (start) begin enter(M_EXT); m_busy = 1'b1; end
          else if (cyc - m_enter == FREE_CYC) enter(M_IDLE);
        M_GRANTED:
          if (start) begin enter(M_OWNED); m_busy = 1'b1; end
          else if (!req[m_who]) begin enter(M_IDLE); m_grant = 2'b00; end
          else if (cyc - m_enter == GRANT_TO) begin enter(M_IDLE); m_grant = 2'b00; m_err = 1'b1; end
        default:
          if (stop || stuck) begin
            enter(M_WAIT);
            m_grant = 2'b00; m_busy = 1'b0; m_err = stuck && !stop;
          end
      endcase
    end
    m_hold = !rst && req[0] && !m_grant[0];
    if (scl_in) m_last_high = cyc;
    h_scl2 = h_scl1; h_sda2 = h_sda1;
    h_scl1 = rst ? 1'b1 : scl_in;
    h_sda1 = rst ? 1'b1 : sda_in;
    h_rst1 = rst;
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    model_step();
    #1;
    check_eq("grant", 32'(grant), 32'(m_grant));
    check_eq("bus_busy", 32'(bus_busy), 32'(m_busy));
    check_eq("hold_host", 32'(hold_host), 32'(m_hold));
    check_eq("bus_err", 32'(bus_err), 32'(m_err));
    check_eq("grant_onehot0", 32'($onehot0(grant)), 32'(1));
  endtask

  task automatic bus_idle(input int n);
    scl_in = 1'b1; sda_in = 1'b1;
    repeat (n) tick();
  endtask

  task automatic bus_start();
    scl_in = 1'b1; sda_in = 1'b1; tick(); tick();
    sda_in = 1'b0; tick(); tick();
    scl_in = 1'b0; tick();
  endtask

  task automatic bus_rstart();
    scl_in = 1'b0; sda_in = 1'b1; tick();
    scl_in = 1'b1; tick(); tick();
    sda_in = 1'b0; tick(); tick();
    scl_in = 1'b0; tick();
  endtask

  task automatic bus_bits(input int nb);
    for (int i = 0; i < nb; i++) begin
      scl_in = 1'b0; sda_in = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 3)) tick();
      scl_in = 1'b1;
      repeat ($urandom_range(2, 4)) tick();
      scl_in = 1'b0; tick();
    end
  endtask

  task automatic bus_stop();
    scl_in = 1'b0; sda_in = 1'b0; tick();
    scl_in = 1'b1; tick(); tick();
    sda_in = 1'b1; tick(); tick();
  endtask

  task automatic wait_grant(input string tag, input logic [1:0] want, input int limit, output int waited);
    waited = 0;
    while (grant !== want && waited < limit) begin
      tick();
      waited++;
    end
    check_eq(tag, 32'(grant), 32'(want));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int k, errs, act;

    // Reset state, then host request: WAIT_FREE after release, grant, one transfer.
    rst = 1'b1; req = 2'b00;
    bus_idle(3);
    check_eq("rst_grant", 32'(grant), 32'(0));
    check_eq("rst_busy", 32'(bus_busy), 32'(0));
    rst = 1'b0; req = 2'b01;
    repeat (17) tick();
    check_eq("s1_no_early_grant", 32'(grant), 32'(0));
    wait_grant("s1_grant", 2'b01, 40, k);
    bus_start();
    check_eq("s1_busy_after_start", 32'(bus_busy), 32'(1));
    bus_bits(9);
    bus_stop();
    check_eq("s1_grant_after_stop", 32'(grant), 32'(0));
    check_eq("s1_busy_after_stop", 32'(bus_busy), 32'(0));
    wait_grant("s1_regrant", 2'b01, 40, k);
    check_eq("s1_free_gap", 32'(k >= FREE_CYC), 32'(1));
    req = 2'b00; bus_idle(3);

    // Both requesters from reset: host first, then EDID master.
    rst = 1'b1; bus_idle(2);
    rst = 1'b0; req = 2'b11;
    wait_grant("s2_first", 2'b01, 40, k);
    bus_start();
    req = 2'b10;
    bus_bits(9);
    bus_stop();
    wait_grant("s2_second", 2'b10, 40, k);
    req = 2'b00; bus_idle(3);

    // Grant timeout for the EDID master.
    req = 2'b10;
    wait_grant("s3_grant", 2'b10, 10, k);
    wait_grant("s3_revoked", 2'b00, GRANT_TO + 10, k);
    check_eq("s3_timeout_len", 32'(k), 32'(GRANT_TO));
    check_eq("s3_err_pulse", 32'(bus_err), 32'(1));
    tick();
    check_eq("s3_err_one_cycle", 32'(bus_err), 32'(0));
    check_eq("s3_back_in_idle", 32'(grant), 32'(2'b10));
    req = 2'b00; bus_idle(4);

    // Foreign START in IDLE while the host asks for the bus.
    sda_in = 1'b0; tick();
    req = 2'b01; tick();
    check_eq("s4_no_grant", 32'(grant), 32'(0));
    check_eq("s4_busy", 32'(bus_busy), 32'(1));
    tick();
    check_eq("s4_hold", 32'(hold_host), 32'(1));
    scl_in = 1'b0; tick();
    bus_bits(9);
    bus_stop();
    check_eq("s4_hold_after_stop", 32'(hold_host), 32'(1));
    wait_grant("s4_grant", 2'b01, 40, k);
    check_eq("s4_free_gap", 32'(k >= FREE_CYC), 32'(1));
    check_eq("s4_hold_released", 32'(hold_host), 32'(0));
    req = 2'b00; bus_idle(3);

    // Reset while owning the bus.
    req = 2'b01;
    wait_grant("s5_grant", 2'b01, 40, k);
    bus_start();
    bus_bits(3);
    rst = 1'b1; scl_in = 1'b1; sda_in = 1'b1; tick();
    check_eq("s5_rst_grant", 32'(grant), 32'(0));
    check_eq("s5_rst_busy", 32'(bus_busy), 32'(0));
    rst = 1'b0;
    wait_grant("s5_regrant", 2'b01, 40, k);
    check_eq("s5_idle_gap", 32'(k >= FREE_CYC), 32'(1));
    req = 2'b00; bus_idle(3);

    // SCL held low while owned; requester withdraws, ownership is not affected by req.
    req = 2'b01;
    wait_grant("s6_grant", 2'b01, 40, k);
    bus_start();
    req = 2'b00; scl_in = 1'b0;
    errs = 0;
    repeat (STUCK_TO + 20) begin
      tick();
      errs += int'(bus_err);
    end
`ifdef DDC_ARB_STUCK_WDT_EN
    check_eq("s6_err_pulses", 32'(errs), 32'(1));
    check_eq("s6_grant", 32'(grant), 32'(0));
    check_eq("s6_busy", 32'(bus_busy), 32'(0));
`else
    check_eq("s6_err_pulses", 32'(errs), 32'(0));
    check_eq("s6_grant", 32'(grant), 32'(2'b01));
    check_eq("s6_busy", 32'(bus_busy), 32'(1));
`endif
    bus_stop();
    bus_idle(20);

    // Random traffic against the model.
    for (int it = 0; it < 80; it++) begin
      act = $urandom_range(0, 9);
      if ($urandom_range(0, 2) == 0) req = 2'($urandom_range(0, 3));
      case (act)
        0, 1, 2: bus_idle($urandom_range(1, 30));
        3, 4, 5: begin
          bus_start();
          bus_bits($urandom_range(1, 18));
          if ($urandom_range(0, 1) == 1) begin
            bus_rstart();
            bus_bits($urandom_range(1, 9));
          end
          bus_stop();
          bus_idle($urandom_range(1, 5));
        end
        6: begin
          bus_start();
          bus_stop();
        end
        7: begin
          scl_in = 1'b0; sda_in = 1'b1;
          repeat ($urandom_range(1, 40)) tick();
          bus_idle(1);
        end
        8: begin
          rst = 1'b1; bus_idle($urandom_range(1, 2));
          rst = 1'b0;
        end
        default: begin
          req = 2'b00; bus_idle(3);
        end
      endcase
    end
    bus_idle(5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
